// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with valid/ready handshake.
//
// Captures the execute-stage bundle and holds it for the memory stage.
// It adds a valid/ready handshake and stall back-pressure. A synchronous
// flush squashes all held bundles and inserts a bubble. Forwarding taps come
// straight from the main register.
//
// Build option: define EX_MEM_SKID_EN to add a second (skid) entry. With it,
// in_ready is a register and the stage accepts one extra bundle after
// out_ready drops. Without it, in_ready = ~out_valid | out_ready.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   flush                   squash all held entries (wins over input transfer)
//   in_valid / in_ready     EX-side handshake
//   wb_in .. rd_in          EX bundle (control, branch target, ALU result, zero, rd)
//   out_valid / out_ready   MEM-side handshake
//   wb_out .. rd_out        registered bundle; wb_out/m_out read 0 while invalid
//   fwd_regwrite, fwd_rd    forwarding taps from the main register
module ex_mem_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned WB_W = 2,
  parameter int unsigned M_W  = 3,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WB_W-1:0] wb_in,
  input  logic [M_W-1:0]  m_in,
  input  logic [XLEN-1:0] adder_out_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic            zero_in,
  input  logic [RD_W-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WB_W-1:0] wb_out,
  output logic [M_W-1:0]  m_out,
  output logic [XLEN-1:0] adder_out_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic            zero_out,
  output logic [RD_W-1:0] rd_out,
  output logic            fwd_regwrite,
  output logic [RD_W-1:0] fwd_rd
);

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [XLEN-1:0] adder;
    logic [XLEN-1:0] alu;
    logic            zero;
    logic [RD_W-1:0] rd;
  } bundle_t;

`ifdef EX_MEM_SKID_EN
  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;
  bundle_t skid_q, skid_d;
  logic    in_ready_q, in_ready_d;
`else
  typedef enum logic {StEmpty, StOne} state_e;
  // Holds in_ready low until the first edge after reset deasserts.
  logic    rst_done_q;
`endif

  state_e  state_q, state_d;
  bundle_t main_q, main_d;
  bundle_t in_bundle;
  logic    in_fire, out_fire;

  assign in_bundle = '{wb: wb_in, m: m_in, adder: adder_out_in, alu: alu_result_in,
                       zero: zero_in, rd: rd_in};

  assign out_valid = (state_q != StEmpty);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef EX_MEM_SKID_EN
  assign in_ready = in_ready_q;
`else
  // With a single entry, an input transfer into a full stage implies an output transfer.
  assign in_ready = rst_done_q & (~out_valid | out_ready);
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef EX_MEM_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_d  = in_bundle;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_d = in_bundle;
`ifdef EX_MEM_SKID_EN
        end else if (in_fire) begin
          skid_d  = in_bundle;
          state_d = StTwo;
`endif
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
`ifdef EX_MEM_SKID_EN
      StTwo: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
`endif
      default: state_d = StEmpty;
    endcase

    // Flush drops any incoming bundle; data fields hold, control fields clear.
    if (flush) begin
      state_d   = StEmpty;
      main_d    = main_q;
      main_d.wb = '0;
      main_d.m  = '0;
`ifdef EX_MEM_SKID_EN
      skid_d    = skid_q;
      skid_d.wb = '0;
      skid_d.m  = '0;
`endif
    end
  end

`ifdef EX_MEM_SKID_EN
  assign in_ready_d = (state_d != StTwo);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEmpty;
      main_q     <= '0;
`ifdef EX_MEM_SKID_EN
      skid_q     <= '0;
      in_ready_q <= 1'b0;
`else
      rst_done_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
`ifdef EX_MEM_SKID_EN
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
`else
      rst_done_q <= 1'b1;
`endif
    end
  end

  // Bubble: control fields read 0 whenever nothing valid is held.
  assign wb_out         = out_valid ? main_q.wb : '0;
  assign m_out          = out_valid ? main_q.m  : '0;
  assign adder_out_out  = main_q.adder;
  assign alu_result_out = main_q.alu;
  assign zero_out       = main_q.zero;
  assign rd_out         = main_q.rd;

  assign fwd_regwrite = out_valid & wb_out[0];
  assign fwd_rd       = main_q.rd;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  localparam int unsigned XLEN = 64;
  localparam int unsigned WB_W = 2;
  localparam int unsigned M_W  = 3;
  localparam int unsigned RD_W = 5;
`ifdef EX_MEM_SKID_EN
  localparam int unsigned Cap = 2;
`else
  localparam int unsigned Cap = 1;
`endif

  logic            clk;
  logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WB_W-1:0] wb_in, wb_out;
  logic [M_W-1:0]  m_in, m_out;
  logic [XLEN-1:0] adder_out_in, alu_result_in, adder_out_out, alu_result_out;
  logic            zero_in, zero_out, fwd_regwrite;
  logic [RD_W-1:0] rd_in, rd_out, fwd_rd;

  ex_mem_stage #(.XLEN(XLEN), .WB_W(WB_W), .M_W(M_W), .RD_W(RD_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_in(wb_in), .m_in(m_in), .adder_out_in(adder_out_in),
    .alu_result_in(alu_result_in), .zero_in(zero_in), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_out(wb_out), .m_out(m_out), .adder_out_out(adder_out_out),
    .alu_result_out(alu_result_out), .zero_out(zero_out), .rd_out(rd_out),
    .fwd_regwrite(fwd_regwrite), .fwd_rd(fwd_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered queue of held bundles with capacity Cap.
  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [XLEN-1:0] adder;
    logic [XLEN-1:0] alu;
    logic            zero;
    logic [RD_W-1:0] rd;
  } bund_t;

  bund_t q[$];
  bund_t last;          // bundle shown on the data outputs
  logic  rst_last;      // previous edge had reset asserted
  logic  known = 1'b0;  // model valid once a reset edge has been seen
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic fl, input logic iv, input logic ordy,
                       input logic ones, input logic [WB_W-1:0] wb, input logic [RD_W-1:0] rd,
                       input logic [XLEN-1:0] alu);
    logic  exp_ov, exp_ir, of, inf;
    bund_t cur;
    @(negedge clk);
    if (ones) begin
      reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      wb_in = '1; m_in = '1; adder_out_in = '1; alu_result_in = '1; zero_in = 1'b1; rd_in = '1;
    end else begin
      reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
      wb_in = wb; rd_in = rd; alu_result_in = alu;
      m_in = M_W'($urandom);
      adder_out_in = {$urandom, $urandom};
      zero_in = 1'($urandom);
    end
    #1;
    exp_ov = (q.size() > 0);
    cur    = exp_ov ? q[0] : last;
`ifdef EX_MEM_SKID_EN
    exp_ir = !rst_last && (q.size() < Cap);
`else
    exp_ir = !rst_last && (q.size() == 0 || out_ready);
`endif
    if (known) begin
      check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
      check_eq("in_ready", 64'(in_ready), 64'(exp_ir));
      check_eq("wb_out", 64'(wb_out), exp_ov ? 64'(cur.wb) : 64'd0);
      check_eq("m_out", 64'(m_out), exp_ov ? 64'(cur.m) : 64'd0);
      check_eq("adder_out_out", adder_out_out, cur.adder);
      check_eq("alu_result_out", alu_result_out, cur.alu);
      check_eq("zero_out", 64'(zero_out), 64'(cur.zero));
      check_eq("rd_out", 64'(rd_out), 64'(cur.rd));
      check_eq("fwd_regwrite", 64'(fwd_regwrite), 64'(exp_ov && cur.wb[0]));
      check_eq("fwd_rd", 64'(fwd_rd), 64'(cur.rd));
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      last = '0;
      rst_last = 1'b1;
      known = 1'b1;
    end else begin
      rst_last = 1'b0;
      of  = exp_ov && out_ready;
      inf = in_valid && exp_ir;
      if (flush) begin
        q.delete();
      end else begin
        if (of) void'(q.pop_front());
        if (inf) q.push_back('{wb: wb_in, m: m_in, adder: adder_out_in, alu: alu_result_in,
                               zero: zero_in, rd: rd_in});
      end
      if (q.size() > 0) last = q[0];
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    wb_in = '0; m_in = '0; adder_out_in = '0; alu_result_in = '0; zero_in = 1'b0; rd_in = '0;
    last = '0; rst_last = 1'b0;

    // Reset with every input high, then release.
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Streaming 1..8 with the sink always ready.
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 5'(i), 64'(i));
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);

    // Stall: A, B, then out_ready low for 3 cycles, then drain.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 5'd1, 64'hA);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 5'd2, 64'hB);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 5'd3, 64'hC);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);

    // Flush while full with a new bundle offered.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 5'd4, 64'hD);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 5'd5, 64'hE);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 5'd6, 64'hF);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);

    // Forwarding: RegWrite bundle to x7, then drain with no new input.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 5'd7, 64'h77);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 96) == 0), 1'($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), 1'b0,
            WB_W'($urandom), RD_W'($urandom), {$urandom, $urandom});
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX/MEM pipeline stage for the five-stage core: it captures the execute-stage bundle (writeback and memory control, branch target, ALU result, zero flag, destination register) and presents it to the memory stage. The capture is a one-cycle register like the basic stage register, extended with a valid/ready handshake, stall back-pressure, synchronous flush with bubble insertion, and forwarding taps. An optional two-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `XLEN`, 64, width of branch-target and ALU-result fields
- `WB_W`, 2, writeback control width; bit 0 is RegWrite
- `M_W`, 3, memory control width
- `RD_W`, 5, destination register index width
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous squash of all held entries
- `in_valid`  in  1  EX bundle valid
- `in_ready`  out  1  stage can accept the bundle this cycle
- `wb_in`, `m_in`  in  WB_W, M_W  control fields
- `adder_out_in`, `alu_result_in`  in  XLEN each  branch target, ALU result
- `zero_in`  in  1  ALU zero flag
- `rd_in`  in  RD_W  destination register
- `out_valid`  out  1  MEM-side bundle valid
- `out_ready`  in  1  MEM stage accepts this cycle
- `wb_out`, `m_out`, `adder_out_out`, `alu_result_out`, `zero_out`, `rd_out`  out  matching widths  registered bundle
- `fwd_regwrite`  out  1  `out_valid & wb_out[0]`, for the forwarding unit
- `fwd_rd`  out  RD_W  equal to `rd_out`

## Operation
- Transfer in: `in_valid & in_ready`. Transfer out: `out_valid & out_ready`.
- Storage: main register (drives outputs) and, with skid enabled, a skid register. Occupancy states: EMPTY, ONE (main only), TWO (main and skid).
- EMPTY, input transfer: load main, go to ONE.
- ONE, input transfer with output transfer: reload main, stay in ONE.
- ONE, input transfer without output transfer: load skid, go to TWO (skid build only).
- ONE, output transfer without input transfer: go to EMPTY.
- TWO, output transfer: move skid to main, go to ONE. Because `in_ready` is 0 in TWO, no input transfer can occur.
- Bubble rule: when `out_valid` is 0, `wb_out` and `m_out` read 0, so no downstream write or memory access can fire. Data fields hold their last value.
- Flush: clears all valid bits, goes to EMPTY, and zeroes the control fields. It has priority over any simultaneous input transfer, which is dropped. The output transfer in the same cycle still counts as consumed.
- Reset: every output goes to 0 (`in_ready` included) and state goes to EMPTY. From the first cycle after reset deasserts, `in_ready` is 1. Reset asserted mid-operation discards all held bundles.
- No arithmetic is performed; fields pass through bit-exact.

## Timing
- Latency: 1 cycle. A bundle accepted at edge N is on the outputs with `out_valid` = 1 after edge N.
- Throughput: 1 bundle per cycle while `out_ready` stays 1.
- Skid build: `in_ready` is a register, high exactly when the skid register is empty. No combinational path runs from `out_ready` to `in_ready`.
- Without skid: `in_ready = ~out_valid | out_ready`, which is combinational.
- Order is preserved. Nothing is dropped or duplicated except on flush or reset.
- `fwd_*` outputs are purely combinational from the main register.

## Configuration
- `EX_MEM_SKID_EN` defined: the skid register and TWO state are built, and `in_ready` is registered. The stage absorbs one extra bundle when `out_ready` drops.
- Not defined: main register only, and the TWO state does not exist. `in_ready` follows the combinational rule above.
- Ports, reset values, latency and flush behaviour are identical in both builds.

## Test plan
- Reset with every input at 1 for 2 cycles, then deasserted: all outputs 0 during reset, then `in_ready` = 1.
- Streaming: alu_result 1..8 sent on consecutive cycles with `out_ready` = 1. The same values appear one cycle later, back-to-back, with `out_valid` = 1 throughout.
- Stall (skid build): send A, then B on the next cycle, then drop `out_ready` for 3 cycles. After B is accepted the stage is in TWO and `in_ready` = 0; `out_valid` holds A. When `out_ready` returns, A then B come out on consecutive cycles.
- Flush with occupancy TWO and `in_valid` = 1: next cycle `out_valid` = 0, `wb_out` = 0, `m_out` = 0, and the flushed bundles never appear.
- Forwarding: accept wb_in = 2'b01, rd_in = 5'd7. Then `fwd_regwrite` = 1 and `fwd_rd` = 7. After output transfer with no new input, `fwd_regwrite` = 0.
